// File: rtl/dsm_pkg.sv
// Shared constants and helpers for the multi-channel delta-sigma modulator.
package dsm_pkg;
    localparam int ORDER_FIRST  = 1;
    localparam int ORDER_SECOND = 2;

    function automatic int midscale(input int width);
        return 1 << (width - 1);
    endfunction

    // Symmetric clamp magnitude for the second-order integrators.
    function automatic int sat_bound(input int width);
        return (1 << (width + 2)) - 1;
    endfunction
endpackage

// File: rtl/dsm_channel.sv
// One delta-sigma modulator channel: first-order carry accumulator or
// second-order saturating double integrator, selected at elaboration.
module dsm_channel
    import dsm_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int ORDER = ORDER_FIRST
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic [WIDTH-1:0] x,
    output logic             y
);
    if (ORDER == ORDER_FIRST) begin : g_first
        // The carry of the WIDTH+1 bit sum is registered directly as y.
        logic [WIDTH-1:0] acc;
        logic [WIDTH:0]   sum;

        assign sum = {1'b0, acc} + {1'b0, x};

        always_ff @(posedge clk) begin
            if (aclr) begin
                acc <= '0;
                y   <= 1'b0;
            end else begin
                acc <= sum[WIDTH-1:0];
                y   <= sum[WIDTH];
            end
        end
    end else if (ORDER == ORDER_SECOND) begin : g_second
        localparam int IW = WIDTH + 4;
        // Sums are formed two bits wider so they cannot wrap before clamping.
        localparam int SW = IW + 2;
        localparam logic signed [SW-1:0] M_S   = SW'(midscale(WIDTH));
        localparam logic signed [SW-1:0] BOUND = SW'(sat_bound(WIDTH));

        logic signed [IW-1:0] i1, i2, i1_next, i2_next;
        logic signed [SW-1:0] i1_x, i2_x, xs, fb, s1, s2;

        assign i1_x = {{(SW-IW){i1[IW-1]}}, i1};
        assign i2_x = {{(SW-IW){i2[IW-1]}}, i2};
        assign xs   = $signed({{(SW-WIDTH){1'b0}}, x}) - M_S;
        assign fb   = y ? M_S : -M_S;
        assign s1   = i1_x + xs - fb;
        assign s2   = i2_x + i1_x - fb;

        always_comb begin
            i1_next = IW'(s1);
            i2_next = IW'(s2);
            if (s1 > BOUND)
                i1_next = IW'(BOUND);
            else if (s1 < -BOUND)
                i1_next = IW'(-BOUND);
            if (s2 > BOUND)
                i2_next = IW'(BOUND);
            else if (s2 < -BOUND)
                i2_next = IW'(-BOUND);
        end

        always_ff @(posedge clk) begin
            if (aclr) begin
                i1 <= '0;
                i2 <= '0;
                y  <= 1'b0;
            end else begin
                i1 <= i1_next;
                i2 <= i2_next;
                y  <= ~i2_next[IW-1];
            end
        end
    end else begin : g_bad_order
        $error("dsm_channel: ORDER must be 1 or 2");
    end
endmodule

// File: rtl/dsm_multi.sv
// Multi-channel delta-sigma DAC front end: shared sample-period counter,
// single-frame holding register, active sample registers and per-channel modulators.
module dsm_multi
    import dsm_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 2,
    parameter int ORDER    = ORDER_FIRST,
    parameter int OSR      = 4096
) (
    input  logic                      clk,
    input  logic                      aclr,
    input  logic [CHANNELS*WIDTH-1:0] pcm_data,
    input  logic                      pcm_valid,
    output logic                      pcm_ready,
    input  logic                      mute,
    output logic [CHANNELS-1:0]       dsm_out,
    output logic                      tick,
    output logic                      underrun
);
    if (WIDTH < 4 || WIDTH > 24 || CHANNELS < 1 || CHANNELS > 8 || OSR < 2 || OSR > 65536)
    begin : g_bad_param
        $error("dsm_multi: parameter out of range");
    end

    localparam int                CW   = $clog2(OSR);
    localparam logic [CW-1:0]     LAST = CW'(OSR - 1);
    localparam logic [WIDTH-1:0]  MID  = WIDTH'(midscale(WIDTH));

    logic [CW-1:0]             count;
    logic                      full;
    logic                      fire;
    logic [CHANNELS*WIDTH-1:0] hold;
    logic [CHANNELS*WIDTH-1:0] active;

    assign pcm_ready = !full;
    assign fire      = pcm_valid && !full;
    assign tick      = (count == LAST);
    assign underrun  = tick && !full && !fire;

    always_ff @(posedge clk) begin
        if (aclr) begin
            count  <= '0;
            full   <= 1'b0;
            hold   <= '0;
            active <= '0;
        end else begin
            count <= tick ? '0 : count + 1'b1;
            if (fire)
                hold <= pcm_data;
            if (tick) begin
                // An empty holding register lets a same-cycle frame bypass it.
                full <= 1'b0;
                if (mute)
                    active <= {CHANNELS{MID}};
                else if (full)
                    active <= hold;
                else if (fire)
                    active <= pcm_data;
            end else if (fire) begin
                full <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        dsm_channel #(
            .WIDTH (WIDTH),
            .ORDER (ORDER)
        ) u_ch (
            .clk  (clk),
            .aclr (aclr),
            .x    (active[k*WIDTH +: WIDTH]),
            .y    (dsm_out[k])
        );
    end
endmodule

// File: tb/tb_dsm_multi.sv
// Self-checking bench for dsm_multi: first-order instance against a frame-level
// model with per-period density counts, plus a second-order instance.
module tb_dsm_multi;
    localparam int WIDTH    = 12;
    localparam int CHANNELS = 2;
    localparam int OSR      = 4096;
    localparam int M        = 2048;
    localparam logic [23:0] MUTE_FRAME = {12'd2048, 12'd2048};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        aclr, pcm_valid, pcm_ready, mute, tick, underrun;
    logic [23:0] pcm_data;
    logic [1:0]  dsm_out;

    logic        aclr2, pcm_valid2, pcm_ready2, mute2, tick2, underrun2;
    logic [23:0] pcm_data2;
    logic [1:0]  dsm_out2;

    dsm_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .ORDER(1), .OSR(OSR)) u_dut1 (
        .clk(clk), .aclr(aclr), .pcm_data(pcm_data), .pcm_valid(pcm_valid),
        .pcm_ready(pcm_ready), .mute(mute), .dsm_out(dsm_out), .tick(tick), .underrun(underrun)
    );

    dsm_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .ORDER(2), .OSR(OSR)) u_dut2 (
        .clk(clk), .aclr(aclr2), .pcm_data(pcm_data2), .pcm_valid(pcm_valid2),
        .pcm_ready(pcm_ready2), .mute(mute2), .dsm_out(dsm_out2), .tick(tick2), .underrun(underrun2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Frame-level model: one-deep frame queue, sample-period count, active frame.
    int          m_cnt = 0;
    logic [23:0] held_q[$];
    logic [23:0] m_active = '0;
    logic [23:0] next_frame;

    always @(posedge clk) begin
        if (aclr) begin
            m_cnt = 0;
            held_q.delete();
            m_active = '0;
        end else if (m_cnt == OSR - 1) begin
            if (held_q.size() != 0)
                next_frame = held_q.pop_front();
            else if (pcm_valid)
                next_frame = pcm_data;
            else
                next_frame = m_active;
            m_active = mute ? MUTE_FRAME : next_frame;
            m_cnt = 0;
        end else begin
            if (pcm_valid && held_q.size() == 0)
                held_q.push_back(pcm_data);
            m_cnt++;
        end
    end

    // Output density equals the active sample over each full period of constant input.
    bit          run_checks = 0;
    bit          win_open = 0;
    logic [23:0] win_x;
    int          ones0, ones1, toggles, n_windows = 0, ur_seen = 0;
    logic        prev0;

    always @(negedge clk) begin
        if (run_checks && !aclr) begin
            check_val("tick", int'(tick), int'(m_cnt == OSR - 1));
            check_val("pcm_ready", int'(pcm_ready), int'(held_q.size() == 0));
            check_val("underrun", int'(underrun),
                      int'(m_cnt == OSR - 1 && held_q.size() == 0 && !pcm_valid));
            if (underrun)
                ur_seen++;
            if (m_cnt == 1) begin
                win_open = 1;
                win_x    = m_active;
                ones0    = int'(dsm_out[0]);
                ones1    = int'(dsm_out[1]);
                toggles  = 0;
                prev0    = dsm_out[0];
            end else if (win_open) begin
                ones0   += int'(dsm_out[0]);
                ones1   += int'(dsm_out[1]);
                toggles += int'(dsm_out[0] != prev0);
                prev0    = dsm_out[0];
                if (m_cnt == 0) begin
                    check_val($sformatf("ones_ch0 x=%0d", win_x[11:0]), ones0, int'(win_x[11:0]));
                    check_val($sformatf("ones_ch1 x=%0d", win_x[23:12]), ones1, int'(win_x[23:12]));
                    if (win_x[11:0] == 12'd2048)
                        check_val("ch0_toggles", toggles, OSR - 1);
                    n_windows++;
                    win_open = 0;
                end
            end
        end else begin
            win_open = 0;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] d);
        int guard = 0;
        pcm_valid = 1'b1;
        pcm_data  = d;
        while (held_q.size() != 0 && guard < 2 * OSR) begin
            step();
            guard++;
        end
        if (guard >= 2 * OSR)
            check_val("send_timeout", guard, 0);
        step();
        pcm_valid = 1'b0;
    endtask

    task automatic wait_tick();
        int guard = 0;
        step();
        while (m_cnt != 0 && guard < 2 * OSR) begin
            step();
            guard++;
        end
        if (guard >= 2 * OSR)
            check_val("tick_timeout", guard, 0);
    endtask

    bit done2 = 0;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Second-order instance: midscale density, then mid-period reset.
    initial begin
        int o0, o1, n;
        aclr2 = 1'b1; pcm_valid2 = 1'b0; pcm_data2 = '0; mute2 = 1'b0;
        step(3);
        aclr2 = 1'b0;
        pcm_valid2 = 1'b1;
        pcm_data2  = {12'd2048, 12'd2048};
        step();
        pcm_valid2 = 1'b0;
        for (int t = 0; t < 2; t++) begin
            n = 0;
            step();
            while (!tick2 && n < 2 * OSR) begin
                step();
                n++;
            end
            check_val("o2_tick_seen", int'(tick2), 1);
        end
        step(100);
        o0 = 0; o1 = 0;
        for (int i = 0; i < OSR; i++) begin
            o0 += int'(dsm_out2[0]);
            o1 += int'(dsm_out2[1]);
            step();
        end
        check_val($sformatf("o2_ch0_within2 ones=%0d", o0), int'(o0 >= M - 2 && o0 <= M + 2), 1);
        check_val($sformatf("o2_ch1_within2 ones=%0d", o1), int'(o1 >= M - 2 && o1 <= M + 2), 1);
        step(1000);
        aclr2 = 1'b1;
        step();
        check_val("o2_rst_dsm_out", int'(dsm_out2), 0);
        check_val("o2_rst_ready", int'(pcm_ready2), 1);
        check_val("o2_rst_tick", int'(tick2), 0);
        check_val("o2_rst_underrun", int'(underrun2), 0);
        aclr2 = 1'b0;
        n = 0;
        while (!tick2 && n < 2 * OSR) begin
            step();
            n++;
        end
        check_val("o2_cycles_to_tick", n, OSR - 1);
        done2 = 1;
    end

    initial begin
        int ur_base;
        aclr = 1'b1; pcm_valid = 1'b0; pcm_data = '0; mute = 1'b0;
        step(3);
        check_val("rst_dsm_out", int'(dsm_out), 0);
        check_val("rst_ready", int'(pcm_ready), 1);
        check_val("rst_tick", int'(tick), 0);
        check_val("rst_underrun", int'(underrun), 0);
        aclr = 1'b0;
        run_checks = 1;

        send({12'd1024, 12'd127});
        wait_tick();
        send({12'd3750, 12'd2048});
        wait_tick();

        ur_base = ur_seen;
        wait_tick();
        wait_tick();
        check_val("underruns_two_ticks", ur_seen - ur_base, 2);

        while (m_cnt != OSR - 1)
            step();
        pcm_valid = 1'b1;
        pcm_data  = {12'd500, 12'd3000};
        #3;
        check_val("ontick_underrun", int'(underrun), 0);
        step();
        pcm_valid = 1'b0;

        send({12'd0, 12'd4095});
        mute = 1'b1;
        wait_tick();
        mute = 1'b0;
        send({12'd0, 12'd4095});
        wait_tick();
        wait_tick();

        for (int r = 0; r < 4; r++) begin
            if ($urandom_range(0, 3) != 0) begin
                step($urandom_range(0, 3000));
                send({12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095))});
            end
            if ($urandom_range(0, 4) == 0)
                mute = 1'b1;
            wait_tick();
            mute = 1'b0;
        end
        wait_tick();
        check_val("windows_checked_min", int'(n_windows >= 11), 1);

        if (!done2) begin
            int g = 0;
            while (!done2 && g < 4 * OSR) begin
                step();
                g++;
            end
        end
        check_val("order2_done", int'(done2), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dsm_multi.md
DSM_MULTI -- requirements
Module: dsm_multi

Interface
REQ-001 Parameter WIDTH, default 12: PCM sample width in bits, unsigned, range 4..24.
REQ-002 Parameter CHANNELS, default 2: number of independent modulator channels, range 1..8.
REQ-003 Parameter ORDER, default 1: modulator order, 1 or 2. Any other value is an elaboration error.
REQ-004 Parameter OSR, default 4096: clocks per sample period, range 2..65536.
REQ-005 clk  input  1  the single clock. All logic is on its rising edge.
REQ-006 aclr  input  1  synchronous, active-high reset.
REQ-007 pcm_data  input  CHANNELS*WIDTH  one frame of samples. Channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 pcm_valid  input  1  pcm_data holds a frame.
REQ-009 pcm_ready  output  1  block can accept a frame.
REQ-010 mute  input  1  force midscale on every channel.
REQ-011 dsm_out  output  CHANNELS  registered 1-bit density stream, one bit per channel.
REQ-012 tick  output  1  one-cycle strobe marking the sample-period boundary.
REQ-013 underrun  output  1  one-cycle pulse on a tick that found no frame available.

Function
REQ-014 Period counter:
- counts 0..OSR-1 and wraps to 0.
- tick = 1 exactly in cycles where count == OSR-1.
REQ-015 Frame handshake:
- holding register: one frame plus a full flag.
- pcm_ready = !full. pcm_ready does not depend combinationally on pcm_valid.
- handshake fires when pcm_valid && pcm_ready.
- a fired handshake sets full and captures pcm_data.
REQ-016 On tick with full = 1:
- holding frame is copied to the active registers.
- full is cleared.
REQ-017 On tick with full = 0 and a handshake firing in the same cycle:
- pcm_data is written straight to the active registers.
- full stays 0.
- no underrun is raised.
REQ-018 On tick with full = 0 and no handshake:
- active registers keep their previous frame.
- underrun pulses high for that one cycle.
REQ-019 If mute = 1 during a tick, every channel's active register is loaded with midscale M = 2^(WIDTH-1), whatever the source. Holding/full behaviour is unchanged by mute.
REQ-020 The new active value takes effect in the modulator on the cycle after the tick. dsm_out reflects it one cycle after that.
REQ-021 ORDER=1, per channel:
- accumulator A is WIDTH+1 bits.
- each cycle, A <= {1'b0, A[WIDTH-1:0]} + x.
- dsm_out <= carry bit A[WIDTH] of the new sum.
- over any 2^WIDTH consecutive cycles with constant x, the number of ones is exactly x.
REQ-022 ORDER=2, per channel:
- signed integrators I1 and I2, each WIDTH+4 bits.
- xs = x - M.
- fb = y ? +M : -M, where y is the current dsm_out bit.
- each cycle: I1 <= sat(I1 + xs - fb); I2 <= sat(I2 + I1 - fb), using the old I1.
- y <= (new I2 >= 0).
- sat clamps to ±(2^(WIDTH+2) - 1).
REQ-023 ORDER=2 is specified stable for x in [M/8, 2M - M/8]. Outside that range, output density is undefined but no integrator may wrap.
REQ-024 All channels share one counter, one holding register and one tick. Each channel's arithmetic is independent.

Reset
REQ-025 While aclr = 1 at a clock edge, the following clear to 0 on that edge:
- counter, full, all accumulators and integrators, active registers, dsm_out, tick, underrun.
- consequence: pcm_ready = 1 in the first cycle after reset.
REQ-026 A reset asserted mid-period discards any held frame and restarts the counter at 0. No tick or underrun is generated for the interrupted period.
REQ-027 With reset active registers at 0 and ORDER=1, dsm_out stays 0 until the first frame becomes active.

Structure
REQ-028 Shared package dsm_pkg holds:
- ORDER legal-value constants.
- midscale function of WIDTH.
- saturation bound function.
REQ-029 Per-channel modulator is sub-module dsm_channel, with parameters WIDTH and ORDER. It is generated CHANNELS times. dsm_multi holds the counter, handshake and active registers.

Verification
REQ-030 Configuration: WIDTH=12, CHANNELS=2, ORDER=1, OSR=4096. Frame {ch1=1024, ch0=127} presented before the first tick -> the following 4096-cycle period contains exactly 127 ones on dsm_out[0] and 1024 ones on dsm_out[1].
REQ-031 Same configuration. Frame {3750, 2048} -> ch0 toggles every cycle once settled, with exactly 2048 ones per period. ch1 has exactly 3750 ones per period.
REQ-032 Withhold frames across two ticks -> underrun pulses once per tick. Previous densities persist. pcm_ready stays 1.
REQ-033 Present a frame on exactly the tick cycle with the holding register empty -> no underrun. The new density starts at the next period.
REQ-034 mute = 1 across a tick with frame {0, 4095} held -> both channels give 2048 ones per period. Deassert mute -> {0, 4095} densities at the next tick.
REQ-035 ORDER=2, input 2048 on both channels -> 2048 ± 2 ones per 4096 cycles. Assert aclr mid-period -> all outputs 0, pcm_ready = 1, and the counter restarts at 0.
